// File: rtl/phase_meas_sched_if.sv
// Measurement-side and loop-filter-side signals of the GPSDO phase-measurement scheduler.
// master drives the measurement strobes and avg_ready; slave is the scheduler itself.
interface phase_meas_sched_if #(
  parameter int PHASE_W = 24
);
  logic               meas_en;
  logic               flag_GPS_posedge;
  logic               Measure_Done;
  logic [PHASE_W-1:0] Measure_Phase;
  logic               avg_ready;
  logic [PHASE_W-1:0] avg_phase;
  logic               avg_valid;
  logic               err_timeout;
  logic               overrun;
  logic               gps_lost;
  logic [7:0]         rej_cnt;
  logic [2:0]         state_o;

  modport master (
    output meas_en, flag_GPS_posedge, Measure_Done, Measure_Phase, avg_ready,
    input  avg_phase, avg_valid, err_timeout, overrun, gps_lost, rej_cnt, state_o
  );

  modport slave (
    input  meas_en, flag_GPS_posedge, Measure_Done, Measure_Phase, avg_ready,
    output avg_phase, avg_valid, err_timeout, overrun, gps_lost, rej_cnt, state_o
  );
endinterface

// File: rtl/phase_meas_sched.sv
// GPSDO phase-measurement scheduler: qualifies GPS-vs-local 1PPS phase samples and averages
// 2^AVG_LOG2 of them for the loop filter. Outlier rejection is built only with MEAS_OUTLIER_REJ_EN.
module phase_meas_sched #(
  parameter int PHASE_W      = 24,
  parameter int AVG_LOG2     = 2,
  parameter int MAX_PHASE    = 1000000,
  parameter int CNT_W        = 28,
  parameter int TIMEOUT_CYC  = 110000000,
  parameter int GPS_MISS_CYC = 120000000
) (
  input logic               CLK_SYS,
  input logic               CLK_RST,
  phase_meas_sched_if.slave bus
);

  localparam int                  ACC_W    = PHASE_W + AVG_LOG2;
  localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]    MISS_MAX = CNT_W'(GPS_MISS_CYC);
  localparam logic [AVG_LOG2-1:0] SMP_LAST = '1;

  if (AVG_LOG2 < 1 || MAX_PHASE < 0 || TIMEOUT_CYC < 2 || GPS_MISS_CYC < 1 ||
      GPS_MISS_CYC >= (1 << CNT_W) || TIMEOUT_CYC > (1 << CNT_W)) begin : g_param_err
    $error("phase_meas_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GPS = 3'd1,
    MEASURE  = 3'd2,
    ACCUM    = 3'd3,
    OUTPUT   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0]  smp_cnt_q, smp_cnt_d;
  logic [PHASE_W-1:0]   sample_q, sample_d;
  logic                 gps_pend_q, gps_pend_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]     miss_q, miss_d;
  logic                 lost_q, lost_d;
  logic [PHASE_W-1:0]   avg_phase_q, avg_phase_d;
  logic                 avg_valid_q, avg_valid_d;
  logic                 err_q, err_d;
  logic                 ovr_q, ovr_d;
  logic                 sample_ok;

`ifdef MEAS_OUTLIER_REJ_EN
  localparam logic [PHASE_W-1:0] MAX_PH = PHASE_W'(MAX_PHASE);
  logic [7:0] rej_q, rej_d;

  assign sample_ok = (sample_q <= MAX_PH);

  always_comb begin
    rej_d = rej_q;
    if (state_q == ACCUM && !sample_ok && rej_q != 8'hFF) rej_d = rej_q + 8'd1;
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) rej_q <= '0;
    else          rej_q <= rej_d;
  end

  assign bus.rej_cnt = rej_q;
`else
  assign sample_ok   = 1'b1;
  assign bus.rej_cnt = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    smp_cnt_d   = smp_cnt_q;
    sample_d    = sample_q;
    gps_pend_d  = 1'b0;
    tmo_d       = tmo_q;
    avg_phase_d = avg_phase_q;
    avg_valid_d = avg_valid_q;
    err_d       = 1'b0;
    ovr_d       = 1'b0;
    acc_sum     = acc_q + {{AVG_LOG2{1'b0}}, sample_q};

    unique case (state_q)
      IDLE: begin
        acc_d       = '0;
        smp_cnt_d   = '0;
        avg_valid_d = 1'b0;
        if (bus.meas_en) state_d = WAIT_GPS;
      end
      WAIT_GPS: begin
        if (bus.flag_GPS_posedge) begin
          state_d = MEASURE;
          tmo_d   = '0;
        end
      end
      MEASURE: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.Measure_Done) begin
          // A GPS edge coincident with the local edge starts the next measurement straight after ACCUM.
          sample_d   = bus.Measure_Phase;
          gps_pend_d = bus.flag_GPS_posedge;
          state_d    = ACCUM;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = WAIT_GPS;
        end
      end
      ACCUM: begin
        if (gps_pend_q) begin
          state_d = MEASURE;
          tmo_d   = '0;
        end else begin
          state_d = WAIT_GPS;
        end
        if (sample_ok) begin
          acc_d     = acc_sum;
          smp_cnt_d = smp_cnt_q + 1'b1;
          if (smp_cnt_q == SMP_LAST) begin
            avg_phase_d = acc_sum[ACC_W-1:AVG_LOG2];
            avg_valid_d = 1'b1;
            acc_d       = '0;
            state_d     = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (bus.Measure_Done) ovr_d = 1'b1;
        if (bus.avg_ready) begin
          avg_valid_d = 1'b0;
          state_d     = WAIT_GPS;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.meas_en) begin
      state_d     = IDLE;
      avg_valid_d = 1'b0;
    end
  end

  // GPS-loss watchdog is frozen while the scheduler is disabled.
  always_comb begin
    miss_d = miss_q;
    lost_d = lost_q;
    if (state_q != IDLE) begin
      if (bus.flag_GPS_posedge) begin
        miss_d = '0;
        lost_d = 1'b0;
      end else if (miss_q != MISS_MAX) begin
        miss_d = miss_q + 1'b1;
        if (miss_d == MISS_MAX) lost_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      smp_cnt_q   <= '0;
      sample_q    <= '0;
      gps_pend_q  <= 1'b0;
      tmo_q       <= '0;
      miss_q      <= '0;
      lost_q      <= 1'b0;
      avg_phase_q <= '0;
      avg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      smp_cnt_q   <= smp_cnt_d;
      sample_q    <= sample_d;
      gps_pend_q  <= gps_pend_d;
      tmo_q       <= tmo_d;
      miss_q      <= miss_d;
      lost_q      <= lost_d;
      avg_phase_q <= avg_phase_d;
      avg_valid_q <= avg_valid_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.avg_phase   = avg_phase_q;
  assign bus.avg_valid   = avg_valid_q;
  assign bus.err_timeout = err_q;
  assign bus.overrun     = ovr_q;
  assign bus.gps_lost    = lost_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_phase_meas_sched.sv
// Self-checking bench for phase_meas_sched: random phase samples against a queue-based averaging model,
// plus directed timeout, overrun, GPS-loss, disable and reset scenarios. Honours MEAS_OUTLIER_REJ_EN.
module tb_phase_meas_sched;

  localparam int PHASE_W      = 24;
  localparam int AVG_LOG2     = 2;
  localparam int N_AVG        = 1 << AVG_LOG2;
  localparam int MAX_PHASE    = 1000;
  localparam int TIMEOUT_CYC  = 50;
  localparam int GPS_MISS_CYC = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  phase_meas_sched_if #(.PHASE_W(PHASE_W)) bus ();

  phase_meas_sched #(
    .PHASE_W      (PHASE_W),
    .AVG_LOG2     (AVG_LOG2),
    .MAX_PHASE    (MAX_PHASE),
    .CNT_W        (28),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .GPS_MISS_CYC (GPS_MISS_CYC)
  ) dut (
    .CLK_SYS (clk),
    .CLK_RST (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted samples waiting to form an average, and the expected reject count.
  int acc_q[$];
  int exp_rej  = 0;
  int last_avg = 0;

  function automatic bit model_accepts(input int ph);
`ifdef MEAS_OUTLIER_REJ_EN
    return ph <= MAX_PHASE;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_sample(input int ph, output bit due, output int avg);
    longint sum;
    due = 1'b0;
    avg = 0;
    if (model_accepts(ph)) begin
      acc_q.push_back(ph);
      if (acc_q.size() == N_AVG) begin
        sum = 0;
        foreach (acc_q[i]) sum += acc_q[i];
        avg = int'(sum / N_AVG);
        due = 1'b1;
        acc_q.delete();
      end
    end else if (exp_rej < 255) begin
      exp_rej++;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic gps_pulse();
    bus.flag_GPS_posedge = 1'b1;
    tick();
    bus.flag_GPS_posedge = 1'b0;
  endtask

  // Issues a Measure_Done while in MEASURE and checks the ACCUM step and any resulting average.
  task automatic finish_done(input int ph, input bit with_gps);
    bit       due;
    int       exp_avg;
    logic [2:0] exp_state;
    logic     exp_valid;
    bus.Measure_Done     = 1'b1;
    bus.Measure_Phase    = PHASE_W'(ph);
    bus.flag_GPS_posedge = with_gps;
    tick();
    bus.Measure_Done     = 1'b0;
    bus.flag_GPS_posedge = 1'b0;
    model_sample(ph, due, exp_avg);
    checks++;
    if (bus.state_o !== 3'd3 || bus.avg_valid !== 1'b0) begin
      failures++;
      $display("FAIL accum_entry ph=%0d state=%0d valid=%0b expected state=3 valid=0", ph, bus.state_o, bus.avg_valid);
    end
    tick();
    checks++;
    if (due) begin
      if (bus.avg_valid !== 1'b1 || bus.avg_phase !== PHASE_W'(exp_avg) || bus.state_o !== 3'd4) begin
        failures++;
        $display("FAIL avg_out valid=%0b avg=%0d state=%0d expected valid=1 avg=%0d state=4",
                 bus.avg_valid, bus.avg_phase, bus.state_o, exp_avg);
      end
      last_avg = exp_avg;
    end else begin
      exp_state = with_gps ? 3'd2 : 3'd1;
      if (bus.avg_valid !== 1'b0 || bus.state_o !== exp_state) begin
        failures++;
        $display("FAIL accum_exit valid=%0b state=%0d expected valid=0 state=%0d", bus.avg_valid, bus.state_o, exp_state);
      end
    end
    tick();
    exp_valid = due && !bus.avg_ready;
    checks++;
    if (bus.avg_valid !== exp_valid || bus.rej_cnt !== 8'(exp_rej)) begin
      failures++;
      $display("FAIL post_xfer valid=%0b rej=%0d expected valid=%0b rej=%0d", bus.avg_valid, bus.rej_cnt, exp_valid, exp_rej);
    end
  endtask

  task automatic send_pair(input int ph, input int gap);
    gps_pulse();
    repeat (gap) tick();
    finish_done(ph, 1'b0);
  endtask

  task automatic flush();
    bus.meas_en = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 3'd0 || bus.avg_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle state=%0d valid=%0b expected state=0 valid=0", bus.state_o, bus.avg_valid);
    end
    bus.meas_en = 1'b1;
    tick();
    acc_q.delete();
  endtask

  task automatic test_reset();
    bus.meas_en = 1'b0; bus.flag_GPS_posedge = 1'b0; bus.Measure_Done = 1'b0;
    bus.Measure_Phase = '0; bus.avg_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.state_o, bus.avg_valid, bus.err_timeout, bus.overrun, bus.gps_lost} !== 7'd0 ||
        bus.avg_phase !== '0 || bus.rej_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs state=%0d valid=%0b err=%0b ovr=%0b lost=%0b avg=%0d rej=%0d expected all 0",
               bus.state_o, bus.avg_valid, bus.err_timeout, bus.overrun, bus.gps_lost, bus.avg_phase, bus.rej_cnt);
    end
    rst_n = 1'b1; bus.meas_en = 1'b1; bus.avg_ready = 1'b1;
    tick();
    checks++;
    if (bus.state_o !== 3'd1) begin
      failures++;
      $display("FAIL reset_enable state=%0d expected 1", bus.state_o);
    end
  endtask

  task automatic test_basic_average();
    int phs[4] = '{100, 102, 98, 104};
    foreach (phs[i]) send_pair(phs[i], int'($urandom_range(10, 0)));
  endtask

  task automatic test_random();
    send_pair(0, 0);
    send_pair(MAX_PHASE, 1);
    send_pair(MAX_PHASE + 1, 2);
    for (int i = 0; i < 24; i++) send_pair(int'($urandom_range(2 * MAX_PHASE, 0)), int'($urandom_range(30, 0)));
  endtask

  task automatic test_outlier();
    int phs[5] = '{10, 5000, 20, 30, 40};
    flush();
    foreach (phs[i]) send_pair(phs[i], 1);
`ifdef MEAS_OUTLIER_REJ_EN
    for (int i = 0; i < 260; i++) send_pair(MAX_PHASE + 1 + int'($urandom_range(5000, 0)), 0);
    checks++;
    if (bus.rej_cnt !== 8'd255) begin
      failures++;
      $display("FAIL rej_saturate rej=%0d expected 255", bus.rej_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    int first_err = -1;
    int err_cnt   = 0;
    logic [2:0] st_at_err = '0;
    flush();
    send_pair(555, 2);
    gps_pulse();
    for (int k = 1; k <= 55; k++) begin
      tick();
      if (bus.err_timeout === 1'b1) begin
        err_cnt++;
        if (first_err < 0) begin
          first_err = k;
          st_at_err = bus.state_o;
        end
      end
    end
    checks++;
    if (first_err !== TIMEOUT_CYC || err_cnt !== 1 || st_at_err !== 3'd1) begin
      failures++;
      $display("FAIL timeout_pulse at=%0d pulses=%0d state=%0d expected at=%0d pulses=1 state=1",
               first_err, err_cnt, st_at_err, TIMEOUT_CYC);
    end
    send_pair(1, 0);
    send_pair(2, 3);
    send_pair(3, 5);
  endtask

  task automatic test_simultaneous();
    flush();
    gps_pulse();
    repeat (3) tick();
    finish_done(7, 1'b1);
    finish_done(9, 1'b0);
    send_pair(11, 2);
    send_pair(13, 0);
  endtask

  task automatic test_overrun();
    int held;
    int pulses = 0;
    flush();
    bus.avg_ready = 1'b0;
    for (int i = 0; i < N_AVG; i++) send_pair(int'($urandom_range(MAX_PHASE, 0)), int'($urandom_range(5, 0)));
    held = last_avg;
    for (int i = 0; i < 3; i++) begin
      gps_pulse();
      repeat (int'($urandom_range(4, 0))) tick();
      bus.Measure_Done = 1'b1;
      bus.Measure_Phase = PHASE_W'($urandom_range(MAX_PHASE, 0));
      tick();
      bus.Measure_Done = 1'b0;
      if (bus.overrun === 1'b1) pulses++;
      checks++;
      if (bus.avg_valid !== 1'b1 || bus.avg_phase !== PHASE_W'(held) || bus.state_o !== 3'd4) begin
        failures++;
        $display("FAIL overrun_hold valid=%0b avg=%0d state=%0d expected valid=1 avg=%0d state=4",
                 bus.avg_valid, bus.avg_phase, bus.state_o, held);
      end
      tick();
      if (bus.overrun === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL overrun_count got=%0d expected 3", pulses);
    end
    bus.avg_ready = 1'b1;
    tick();
    checks++;
    if (bus.avg_valid !== 1'b0 || bus.state_o !== 3'd1) begin
      failures++;
      $display("FAIL overrun_release valid=%0b state=%0d expected valid=0 state=1", bus.avg_valid, bus.state_o);
    end
  endtask

  task automatic test_meas_en();
    flush();
    send_pair(500, 1);
    send_pair(600, 1);
    gps_pulse();
    tick();
    bus.meas_en = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 3'd0 || bus.avg_valid !== 1'b0 || bus.rej_cnt !== 8'(exp_rej) || bus.gps_lost !== 1'b0) begin
      failures++;
      $display("FAIL disable_measure state=%0d valid=%0b rej=%0d lost=%0b expected state=0 valid=0 rej=%0d lost=0",
               bus.state_o, bus.avg_valid, bus.rej_cnt, bus.gps_lost, exp_rej);
    end
    bus.meas_en = 1'b1;
    acc_q.delete();
    tick();
    for (int i = 0; i < N_AVG; i++) send_pair(int'($urandom_range(MAX_PHASE, 0)), 1);
    bus.avg_ready = 1'b0;
    for (int i = 0; i < N_AVG; i++) send_pair(int'($urandom_range(MAX_PHASE, 0)), 0);
    bus.meas_en = 1'b0;
    tick();
    checks++;
    if (bus.state_o !== 3'd0 || bus.avg_valid !== 1'b0) begin
      failures++;
      $display("FAIL disable_output state=%0d valid=%0b expected state=0 valid=0", bus.state_o, bus.avg_valid);
    end
    bus.meas_en = 1'b1;
    bus.avg_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    send_pair(300, 1);
    send_pair(301, 1);
    gps_pulse();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 3'd0 || bus.avg_valid !== 1'b0 || bus.rej_cnt !== 8'd0) begin
      failures++;
      $display("FAIL async_reset state=%0d valid=%0b rej=%0d expected 0 0 0", bus.state_o, bus.avg_valid, bus.rej_cnt);
    end
    acc_q.delete();
    exp_rej = 0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N_AVG; i++) send_pair(int'($urandom_range(MAX_PHASE, 0)), int'($urandom_range(8, 0)));
  endtask

  task automatic test_gps_lost();
    int first_lost = -1;
    gps_pulse();
    for (int k = 1; k <= GPS_MISS_CYC + 5; k++) begin
      tick();
      if (bus.gps_lost === 1'b1 && first_lost < 0) first_lost = k;
    end
    checks++;
    if (first_lost !== GPS_MISS_CYC) begin
      failures++;
      $display("FAIL gps_lost_rise at=%0d expected %0d", first_lost, GPS_MISS_CYC);
    end
    gps_pulse();
    checks++;
    if (bus.gps_lost !== 1'b0) begin
      failures++;
      $display("FAIL gps_lost_clear lost=%0b expected 0", bus.gps_lost);
    end
  endtask

  initial begin
    test_reset();
    test_basic_average();
    test_random();
    test_outlier();
    test_timeout();
    test_simultaneous();
    test_overrun();
    test_meas_en();
    test_async_reset();
    test_gps_lost();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal;
  end

endmodule
